// File: rtl/div_pkg.sv
// Shared definitions for the iterative divider: FSM state encoding and
// handshake level constants used by the top and by any bus master.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;
  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;

endpackage

// File: rtl/div_iter_if.sv
// Request/result bundle between a pipeline (master) and the divider (slave).
interface div_iter_if #(
  parameter int WIDTH = 32
);

  logic                   signed_div_i;
  logic [WIDTH-1:0]       opdata1_i;
  logic [WIDTH-1:0]       opdata2_i;
  logic                   start_i;
  logic                   annul_i;
  logic [2*WIDTH-1:0]     result_o;
  logic                   ready_o;
  logic                   busy_o;
  logic                   div_zero_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o, busy_o, div_zero_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o, busy_o, div_zero_o
  );

endinterface

// File: rtl/lzc.sv
// Combinational leading-zero counter; an all-zero input yields WIDTH.
module lzc #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]           data,
  output logic [$clog2(WIDTH+1)-1:0] count
);

  localparam int CW = $clog2(WIDTH + 1);

  // Scan upward so the highest set bit has the final say.
  always_comb begin
    count = CW'(WIDTH);
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (data[i]) count = CW'(WIDTH - 1 - i);
    end
  end

endmodule

// File: rtl/div_iter.sv
// Iterative restoring radix-2 divider, signed or unsigned, with optional
// early exit that skips the leading zeros of the dividend magnitude.
// Result is {remainder, quotient}; latency is N+2 edges after accept.
module div_iter
  import div_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  div_iter_if.slave  bus
);

  localparam int CW = $clog2(WIDTH + 1);

  div_state_e           state;
  logic [CW-1:0]        cnt;
  logic [WIDTH-1:0]     dvd;
  logic [WIDTH-1:0]     rem;
  logic [WIDTH-1:0]     dvs;
  logic [WIDTH-1:0]     dvd_raw;
  logic                 sgn;
  logic                 dvd_neg;
  logic                 dvs_neg;
  logic                 dz;
  logic [2*WIDTH-1:0]   result;
  logic                 ready;
  logic                 div_zero;

  logic [WIDTH-1:0]     mag_a;
  logic [WIDTH-1:0]     mag_b;
  logic [CW-1:0]        lz;
  logic [CW-1:0]        n_acc;
  logic [CW-1:0]        pre_shift;
  logic [WIDTH:0]       rem_shift;
  logic [WIDTH:0]       trial;

  function automatic logic [WIDTH-1:0] neg(input logic [WIDTH-1:0] x);
    return (~x) + 1'b1;
  endfunction

  // Operand magnitudes as seen on the bus, used only at accept.
  always_comb begin
    mag_a = (bus.signed_div_i && bus.opdata1_i[WIDTH-1]) ? neg(bus.opdata1_i) : bus.opdata1_i;
    mag_b = (bus.signed_div_i && bus.opdata2_i[WIDTH-1]) ? neg(bus.opdata2_i) : bus.opdata2_i;
  end

  lzc #(.WIDTH(WIDTH)) u_lzc (
    .data  (mag_a),
    .count (lz)
  );

  // Iteration count and dividend pre-shift chosen at accept.
  always_comb begin
    pre_shift = '0;
    if (mag_b == '0) begin
      n_acc = '0;
    end else if (EARLY_EXIT) begin
      n_acc     = CW'(WIDTH) - lz;
      pre_shift = lz;
    end else begin
      n_acc = CW'(WIDTH);
    end
  end

  // One restoring step: shift in the next dividend bit, trial subtract.
  always_comb begin
    rem_shift = {rem, dvd[WIDTH-1]};
    trial     = rem_shift - {1'b0, dvs};
  end

  // Divider FSM. Quotient bits shift into the low end of dvd as dividend
  // bits leave the top; DONE spends its first cycle publishing the result.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state    <= IDLE;
      ready    <= DivResultNotReady;
      div_zero <= 1'b0;
      result   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start_i == DivStart && !bus.annul_i) begin
            dvd_raw <= bus.opdata1_i;
            sgn     <= bus.signed_div_i;
            dvd_neg <= bus.signed_div_i && bus.opdata1_i[WIDTH-1];
            dvs_neg <= bus.signed_div_i && bus.opdata2_i[WIDTH-1];
            dz      <= (mag_b == '0);
            cnt     <= n_acc;
            dvd     <= mag_a << pre_shift;
            rem     <= '0;
            dvs     <= mag_b;
            state   <= (n_acc != '0) ? CALC : FIX;
          end
        end
        CALC: begin
          if (bus.annul_i) begin
            state <= IDLE;
          end else begin
            if (!trial[WIDTH]) begin
              rem <= trial[WIDTH-1:0];
              dvd <= {dvd[WIDTH-2:0], 1'b1};
            end else begin
              rem <= rem_shift[WIDTH-1:0];
              dvd <= {dvd[WIDTH-2:0], 1'b0};
            end
            cnt <= cnt - 1'b1;
            if (cnt == CW'(1)) state <= FIX;
          end
        end
        FIX: begin
          if (bus.annul_i) begin
            state <= IDLE;
          end else begin
            if (dz) begin
              dvd <= '1;
              rem <= dvd_raw;
            end else begin
              if (sgn && (dvd_neg ^ dvs_neg)) dvd <= neg(dvd);
              if (sgn && dvd_neg)             rem <= neg(rem);
            end
            state <= DONE;
          end
        end
        DONE: begin
          if (ready == DivResultNotReady) begin
            result   <= {rem, dvd};
            div_zero <= dz;
            ready    <= DivResultReady;
          end else if (bus.start_i == DivStop) begin
            state    <= IDLE;
            ready    <= DivResultNotReady;
            div_zero <= 1'b0;
            result   <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.result_o   = result;
  assign bus.ready_o    = ready;
  assign bus.div_zero_o = div_zero;
  assign bus.busy_o     = (state != IDLE);

endmodule

// File: tb/tb_div_iter.sv
// Bench for div_iter: an early-exit and a fixed-latency instance receive the
// same stimulus and are compared against an arithmetic reference model.
module tb_div_iter;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          sgn;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          start;
  logic          annul;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  div_iter_if #(.WIDTH(W)) bus_ee ();
  div_iter_if #(.WIDTH(W)) bus_fx ();

  assign bus_ee.signed_div_i = sgn;
  assign bus_ee.opdata1_i    = a;
  assign bus_ee.opdata2_i    = b;
  assign bus_ee.start_i      = start;
  assign bus_ee.annul_i      = annul;
  assign bus_fx.signed_div_i = sgn;
  assign bus_fx.opdata1_i    = a;
  assign bus_fx.opdata2_i    = b;
  assign bus_fx.start_i      = start;
  assign bus_fx.annul_i      = annul;

  div_iter #(.WIDTH(W), .EARLY_EXIT(1'b1)) u_ee (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus_ee.slave)
  );

  div_iter #(.WIDTH(W), .EARLY_EXIT(1'b0)) u_fx (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus_fx.slave)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // {div_zero, remainder, quotient} from plain integer division.
  function automatic logic [64:0] model(input logic s, input logic [31:0] x, input logic [31:0] y);
    longint q;
    longint r;
    if (y == 32'd0) return {1'b1, x, 32'hFFFF_FFFF};
    if (s) begin
      q = longint'($signed(x)) / longint'($signed(y));
      r = longint'($signed(x)) % longint'($signed(y));
    end else begin
      q = longint'(x) / longint'(y);
      r = longint'(x) % longint'(y);
    end
    return {1'b0, r[31:0], q[31:0]};
  endfunction

  // Edges from accept to ready: significant bits of |dividend| (or full
  // width without early exit, or none for a zero divisor), plus two.
  function automatic int exp_lat(input bit ee, input logic s, input logic [31:0] x, input logic [31:0] y);
    longint m;
    int     n;
    if (y == 32'd0) return 2;
    if (!ee) return W + 2;
    m = s ? longint'($signed(x)) : longint'(x);
    if (m < 0) m = -m;
    n = 0;
    while (m != 0) begin
      n++;
      m = m >>> 1;
    end
    return n + 2;
  endfunction

  task automatic check_idle(input string tag);
    check({tag, " ee_ready"}, 64'(bus_ee.ready_o), 64'd0);
    check({tag, " fx_ready"}, 64'(bus_fx.ready_o), 64'd0);
    check({tag, " ee_busy"}, 64'(bus_ee.busy_o), 64'd0);
    check({tag, " fx_busy"}, 64'(bus_fx.busy_o), 64'd0);
    check({tag, " ee_result"}, bus_ee.result_o, 64'd0);
    check({tag, " fx_result"}, bus_fx.result_o, 64'd0);
    check({tag, " ee_dz"}, 64'(bus_ee.div_zero_o), 64'd0);
    check({tag, " fx_dz"}, 64'(bus_fx.div_zero_o), 64'd0);
  endtask

  // Issue one operation on both instances, scramble the operands after
  // accept, hold start_i for extra cycles in DONE, then release it.
  task automatic do_op(input logic s, input logic [31:0] x, input logic [31:0] y,
                       input string tag, input int hold);
    logic [64:0] exp;
    int lat_ee;
    int lat_fx;
    exp    = model(s, x, y);
    lat_ee = -1;
    lat_fx = -1;
    sgn    = s;
    a      = x;
    b      = y;
    start  = 1'b1;
    for (int c = 0; c < 80 && (lat_ee < 0 || lat_fx < 0); c++) begin
      @(posedge clk);
      #1;
      if (bus_ee.ready_o && lat_ee < 0) lat_ee = c;
      if (bus_fx.ready_o && lat_fx < 0) lat_fx = c;
      if (c == 0) begin
        sgn = 1'($urandom);
        a   = $urandom;
        b   = $urandom;
      end
    end
    check({tag, " ee_latency"}, 64'(lat_ee), 64'(exp_lat(1'b1, s, x, y)));
    check({tag, " fx_latency"}, 64'(lat_fx), 64'(exp_lat(1'b0, s, x, y)));
    check({tag, " ee_result"}, bus_ee.result_o, exp[63:0]);
    check({tag, " fx_result"}, bus_fx.result_o, exp[63:0]);
    check({tag, " ee_dz"}, 64'(bus_ee.div_zero_o), 64'(exp[64]));
    check({tag, " fx_dz"}, 64'(bus_fx.div_zero_o), 64'(exp[64]));
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      check({tag, " hold_ee_result"}, bus_ee.result_o, exp[63:0]);
      check({tag, " hold_fx_result"}, bus_fx.result_o, exp[63:0]);
      check({tag, " hold_ee_ready"}, 64'(bus_ee.ready_o), 64'd1);
      check({tag, " hold_fx_ready"}, 64'(bus_fx.ready_o), 64'd1);
    end
    start = 1'b0;
    @(posedge clk);
    #1;
    check_idle({tag, " release"});
  endtask

  initial begin
    rst   = 1'b1;
    flush = 1'b0;
    sgn   = 1'b0;
    a     = '0;
    b     = '0;
    start = 1'b0;
    annul = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_idle("reset");

    // Idle ignores operand changes without start_i.
    a = 32'd1234;
    b = 32'd5;
    @(posedge clk);
    #1;
    check_idle("idle_no_start");

    do_op(1'b0, 32'd100, 32'd7, "u100_7", 0);
    do_op(1'b1, 32'hFFFF_FFF9, 32'd2, "s_m7_2", 0);
    do_op(1'b0, 32'd5, 32'd0, "u5_0", 0);
    do_op(1'b1, 32'hFFFF_FFF6, 32'd0, "s_m10_0", 0);
    do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "s_minneg", 0);
    do_op(1'b0, 32'd0, 32'd9, "u0_9", 0);
    do_op(1'b0, 32'hFFFF_FFFF, 32'd1, "umax_1", 0);

    // Flush in CALC step 5, asserted together with start_i.
    sgn   = 1'b0;
    a     = 32'd100;
    b     = 32'd7;
    start = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      check("flush_pre ee_ready", 64'(bus_ee.ready_o), 64'd0);
    end
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    start = 1'b0;
    check_idle("flush");

    // Annul in CALC step 5 with start_i still high.
    start = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      check("annul_pre ee_ready", 64'(bus_ee.ready_o), 64'd0);
    end
    annul = 1'b1;
    @(posedge clk);
    #1;
    check_idle("annul");
    annul = 1'b0;
    start = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      check_idle("annul_after");
    end
    do_op(1'b0, 32'd9, 32'd3, "u9_3", 0);

    // Result held stable across a long start_i hold in DONE.
    do_op(1'b0, 32'd100, 32'd7, "hold10", 10);

    // Randomised operations with a spread of dividend magnitudes.
    for (int i = 0; i < 40; i++) begin
      logic [31:0] rx;
      logic [31:0] ry;
      rx = $urandom >> $urandom_range(0, 31);
      ry = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 9) == 0) ry = 32'd0;
      if ($urandom_range(0, 9) == 0) ry = 32'hFFFF_FFFF;
      if ($urandom_range(0, 9) == 0) rx = 32'h8000_0000;
      if ($urandom_range(0, 3) == 0) rx = $urandom;
      do_op(1'($urandom), rx, ry, $sformatf("rand%0d", i), $urandom_range(0, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/div_iter.md
DIV_ITER -- requirements
Module: div_iter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width (legal 8..64).
REQ-002 SHALL have parameter EARLY_EXIT, default 1; 1 skips iterations for leading zeros of |dividend|, 0 gives fixed latency.
REQ-003 SHALL have port clk  in  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-005 SHALL have port flush  in  1  pipeline flush, synchronous abort.
REQ-006 SHALL have port signed_div_i  in  1  1 = two's-complement divide, 0 = unsigned.
REQ-007 SHALL have port opdata1_i  in  WIDTH  dividend.
REQ-008 SHALL have port opdata2_i  in  WIDTH  divisor.
REQ-009 SHALL have port start_i  in  1  request; held high until the result is consumed.
REQ-010 SHALL have port annul_i  in  1  cancel request or in-flight operation.
REQ-011 SHALL have port result_o  out  2*WIDTH  {remainder, quotient}.
REQ-012 SHALL have port ready_o  out  1  result_o valid.
REQ-013 SHALL have port busy_o  out  1  high in every state except IDLE.
REQ-014 SHALL have port div_zero_o  out  1  the current result came from a zero divisor; valid while ready_o is high.

Function
REQ-015 SHALL implement states IDLE, CALC, FIX and DONE.
REQ-016 In IDLE, start_i=1 with annul_i=0 SHALL accept the operation: capture operands, signed_div_i and the operand signs; load the magnitudes.
- Signed mode: magnitude = two's-complement negate when the MSB is set.
- Unsigned mode: magnitude = raw value.
REQ-017 On accept, the iteration count N SHALL be:
- 0 if the divisor is 0;
- else WIDTH - lz(|dividend|) if EARLY_EXIT=1 (lz = leading-zero count; N=0 for dividend 0);
- else WIDTH.
REQ-018 On accept, the dividend SHALL be pre-shifted left by WIDTH-N; next state is CALC if N>0, else FIX.
REQ-019 CALC SHALL perform one restoring radix-2 step per cycle using a WIDTH+1-bit trial subtraction, then go to FIX after N steps.
REQ-020 FIX SHALL apply sign correction in one cycle, then go to DONE.
- Quotient negated when signed and the operand signs differ.
- Remainder negated when signed and the dividend is negative.
REQ-021 A zero divisor SHALL give quotient all-ones, remainder = opdata1 as captured, and div_zero_o=1.
REQ-022 Signed most-negative / -1 SHALL give quotient = most-negative, remainder 0, with no error flag.
REQ-023 Latency SHALL be N+2 cycles: ready_o rises N+2 rising edges after the accepting edge.
REQ-024 In DONE, ready_o=1 and result_o/div_zero_o SHALL hold stable while start_i=1.
REQ-025 In DONE, start_i=0 SHALL return to IDLE, clearing ready_o, result_o and div_zero_o on that edge.
REQ-026 In IDLE, outputs ready_o, result_o and div_zero_o SHALL be 0; new inputs are ignored unless start_i=1.
REQ-027 annul_i=1 in CALC or FIX SHALL return to IDLE next edge with no result; annul_i is ignored in DONE.
REQ-028 flush=1 SHALL act as rst in any state, with priority over start_i and annul_i.
REQ-029 Operands SHALL be sampled only at accept; input changes during CALC/FIX/DONE have no effect.

Reset
REQ-030 On rst=1 at a rising edge: state=IDLE; ready_o=0, busy_o=0, div_zero_o=0, result_o=0.
REQ-031 Reset SHALL abort any in-flight operation; the datapath registers need no reset.

Structure
REQ-032 State encoding, DivStart/DivStop and DivResultReady/NotReady constants SHALL live in the shared package div_pkg.
REQ-033 The leading-zero count SHALL be a separate combinational sub-module lzc, parameterised by WIDTH.

Verification
REQ-034 SHALL cover unsigned 100/7, WIDTH=32, EARLY_EXIT=1 -> quotient 14, remainder 2, ready_o 9 cycles after accept.
REQ-035 SHALL cover signed -7/2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; with EARLY_EXIT=0 the same result arrives after 34 cycles.
REQ-036 SHALL cover 5/0 -> quotient 0xFFFFFFFF, remainder 5, div_zero_o=1, ready_o after 2 cycles.
REQ-037 SHALL cover signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0, div_zero_o=0.
REQ-038 SHALL cover flush, then annul, asserted at CALC step 5 -> IDLE next edge, ready_o never high, and a following 9/3 gives quotient 3, remainder 0.
REQ-039 SHALL cover start_i held 10 cycles in DONE -> result stable; start_i dropped -> next edge has ready_o=0 and result_o=0.
